// File: rtl/psum_accumulator_if.sv
// ---------------------------------------------------------------------------
// psum_accumulator_if : partial-sum input stream and result output stream
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface psum_accumulator_if #(
  parameter int WIDTH = 34
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

`default_nettype wire

// File: rtl/psum_accumulator.sv
// ---------------------------------------------------------------------------
// psum_accumulator : per-tile signed partial-sum accumulator with result FIFO
// Optional PSUM_SAT_EN clamps overflowing sums.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module psum_accumulator #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clr,
  psum_accumulator_if.slave     bus,
  output logic                  ovf
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;

  logic             full, empty, accept, push, pop, over;
  logic [WIDTH-1:0] base, result;
  logic [WIDTH:0]   nsum;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && bus.in_last;
  assign pop    = bus.out_valid && bus.out_ready && !clr;

  assign bus.in_ready  = !full && !clr;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem[rd_ptr];

  assign base = (state == IDLE) ? '0 : acc;
  assign nsum = {base[WIDTH-1], base} + {bus.in_data[WIDTH-1], bus.in_data};
  assign over = (base[WIDTH-1] == bus.in_data[WIDTH-1]) &&
                (nsum[WIDTH-1] != base[WIDTH-1]);

`ifdef PSUM_SAT_EN
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  // Overflow direction follows the common operand sign.
  assign result = !over ? nsum[WIDTH-1:0] : (base[WIDTH-1] ? MIN_NEG : MAX_POS);
`else
  assign result = nsum[WIDTH-1:0];
`endif

  always_comb begin
    state_next = state;
    acc_next   = acc;
    if (clr) begin
      state_next = IDLE;
      acc_next   = '0;
    end else if (accept) begin
      if (bus.in_last) begin
        state_next = IDLE;
        acc_next   = '0;
      end else begin
        state_next = ACCUM;
        acc_next   = result;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      ovf    <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      if (clr) begin
        ovf    <= 1'b0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (accept && over) ovf <= 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= result;
  end
endmodule

`default_nettype wire

// File: tb/tb_psum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_psum_accumulator : vector table, corner sequences and random model check
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_psum_accumulator;
  localparam int WIDTH = 34;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst, clr, ovf;

  psum_accumulator_if #(.WIDTH(WIDTH)) bus();

  psum_accumulator #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .bus(bus), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: tile sum in plain integer arithmetic, queue of totals.
  longint           m_acc;
  bit               m_ovf;
  logic [WIDTH-1:0] m_q[$];

  function automatic longint sext(input logic [WIDTH-1:0] v);
    return longint'($signed(v));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_ovf = 0;
    m_q.delete();
  endtask

  task automatic model_step(input bit v, input logic [WIDTH-1:0] d, input bit l,
                            input bit ordy, input bit c);
    longint maxv, minv, s, r;
    bit     rdy, take, o;
    if (c) begin
      model_reset();
      return;
    end
    maxv = (longint'(1) <<< (WIDTH-1)) - 1;
    minv = -(longint'(1) <<< (WIDTH-1));
    rdy  = m_q.size() < DEPTH;
    take = v && rdy;
    if (m_q.size() > 0 && ordy) void'(m_q.pop_front());
    if (take) begin
      s = m_acc + sext(d);
      o = (s > maxv) || (s < minv);
`ifdef PSUM_SAT_EN
      r = (s > maxv) ? maxv : ((s < minv) ? minv : s);
`else
      r = sext(WIDTH'(s));
`endif
      if (o) m_ovf = 1;
      if (l) begin
        m_q.push_back(WIDTH'(r));
        m_acc = 0;
      end else begin
        m_acc = r;
      end
    end
  endtask

  task automatic set_idle();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    clr           = 1'b0;
  endtask

  // Drive one cycle, step the model at the edge, then idle inputs and settle.
  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit l,
                       input bit ordy, input bit c);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = ordy;
    clr           = c;
    @(posedge clk);
    model_step(v, d, l, ordy, c);
    #1;
    set_idle();
    #1;
  endtask

  task automatic expect_out(input string tag, input bit ev, input logic [WIDTH-1:0] ed,
                            input bit er, input bit eo);
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(ev));
    check({tag, ".out_data"},  64'(bus.out_data),  64'(ed));
    check({tag, ".in_ready"},  64'(bus.in_ready),  64'(er));
    check({tag, ".ovf"},       64'(ovf),           64'(eo));
  endtask

  task automatic check_model(input string tag);
    logic [WIDTH-1:0] hd;
    hd = (m_q.size() > 0) ? m_q[0] : '0;
    expect_out(tag, m_q.size() > 0, hd, m_q.size() < DEPTH, m_ovf);
  endtask

  typedef struct {
    bit               v;
    logic [WIDTH-1:0] d;
    bit               l;
    bit               ordy;
    bit               c;
    bit               ev;
    logic [WIDTH-1:0] ed;
    bit               er;
    bit               eo;
  } vec_t;

  function automatic vec_t mk(input bit v, input longint d, input bit l, input bit ordy,
                              input bit c, input bit ev, input longint ed, input bit er,
                              input bit eo);
    vec_t t;
    t.v = v; t.d = WIDTH'(d); t.l = l; t.ordy = ordy; t.c = c;
    t.ev = ev; t.ed = WIDTH'(ed); t.er = er; t.eo = eo;
    return t;
  endfunction

  logic [WIDTH-1:0] exp_pos, exp_neg, exp_big;

  initial begin
    vec_t tbl[24];
    logic [WIDTH-1:0] rd;
    int sel;

    tbl[0]  = mk(1,  5, 0, 1, 0,  0,  0, 1, 0);
    tbl[1]  = mk(1,  7, 0, 1, 0,  0,  0, 1, 0);
    tbl[2]  = mk(1, -3, 1, 1, 0,  1,  9, 1, 0);
    tbl[3]  = mk(0,  0, 0, 1, 0,  0,  0, 1, 0);
    tbl[4]  = mk(1,  1, 1, 1, 0,  1,  1, 1, 0);
    tbl[5]  = mk(1,  2, 1, 1, 0,  1,  2, 1, 0);
    tbl[6]  = mk(1,  3, 1, 1, 0,  1,  3, 1, 0);
    tbl[7]  = mk(0,  0, 0, 1, 0,  0,  0, 1, 0);
    tbl[8]  = mk(1, 11, 1, 0, 0,  1, 11, 1, 0);
    tbl[9]  = mk(1, 12, 1, 0, 0,  1, 11, 1, 0);
    tbl[10] = mk(1, 13, 1, 0, 0,  1, 11, 1, 0);
    tbl[11] = mk(1, 14, 1, 0, 0,  1, 11, 0, 0);
    tbl[12] = mk(1, 15, 1, 0, 0,  1, 11, 0, 0);
    tbl[13] = mk(1, 15, 1, 1, 0,  1, 12, 1, 0);
    tbl[14] = mk(1, 15, 1, 0, 0,  1, 12, 0, 0);
    tbl[15] = mk(0,  0, 0, 1, 0,  1, 13, 1, 0);
    tbl[16] = mk(0,  0, 0, 1, 0,  1, 14, 1, 0);
    tbl[17] = mk(0,  0, 0, 1, 0,  1, 15, 1, 0);
    tbl[18] = mk(0,  0, 0, 1, 0,  0,  0, 1, 0);
    tbl[19] = mk(1, 10, 0, 1, 0,  0,  0, 1, 0);
    tbl[20] = mk(1, 20, 0, 1, 0,  0,  0, 1, 0);
    tbl[21] = mk(1, 30, 1, 1, 1,  0,  0, 1, 0);
    tbl[22] = mk(1,  4, 1, 1, 0,  1,  4, 1, 0);
    tbl[23] = mk(0,  0, 0, 1, 0,  0,  0, 1, 0);

`ifdef PSUM_SAT_EN
    exp_pos = 34'h1_FFFF_FFFF;
    exp_neg = 34'h2_0000_0000;
    exp_big = 34'h1_FFFF_FFFF;
`else
    exp_pos = 34'h2_0000_0000;
    exp_neg = 34'h1_FFFF_FFFF;
    exp_big = 34'h2_0000_0000;
`endif

    set_idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    expect_out("reset", 0, '0, 1, 0);

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ordy, tbl[i].c);
      expect_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].er, tbl[i].eo);
    end

    drive(1, 34'h1_FFFF_FFFF, 0, 0, 0);
    drive(1, 34'h0_0000_0001, 1, 0, 0);
    expect_out("ovf_pos", 1, exp_pos, 1, 1);
    drive(0, '0, 0, 1, 0);
    drive(1, 34'h2_0000_0000, 0, 0, 0);
    drive(1, 34'h3_FFFF_FFFF, 1, 0, 0);
    expect_out("ovf_neg", 1, exp_neg, 1, 1);
    drive(0, '0, 0, 1, 0);
    drive(1, 34'h0_0000_0006, 1, 1, 0);
    expect_out("ovf_sticky", 1, 34'd6, 1, 1);
    drive(0, '0, 0, 0, 1);
    expect_out("clr_ovf", 0, '0, 1, 0);

    drive(1, 34'h1_0000_0000, 0, 0, 0);
    drive(1, 34'h1_0000_0000, 1, 0, 0);
    drive(1, 34'd7, 1, 0, 0);
    drive(1, 34'd100, 0, 0, 0);
    expect_out("pre_rst", 1, exp_big, 1, 1);
    #2 rst = 1'b1;
    #1;
    expect_out("async_rst", 0, '0, 1, 0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    drive(1, 34'd5, 1, 0, 0);
    expect_out("post_rst", 1, 34'd5, 1, 0);
    drive(0, '0, 0, 1, 0);
    expect_out("post_rst_drain", 0, '0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0:       rd = 34'h1_FFFF_FFFF - WIDTH'($urandom_range(0, 3));
        1:       rd = 34'h2_0000_0000 + WIDTH'($urandom_range(0, 3));
        2:       rd = WIDTH'({$urandom, $urandom});
        default: rd = WIDTH'($signed($urandom_range(0, 2000)) - 1000);
      endcase
      drive($urandom_range(0, 3) != 0, rd, $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0);
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
